// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the mem_ctrl command sequencer.
// ST_CSUM exists only when MEM_CTRL_CSUM_EN is defined.
package mem_ctrl_pkg;

    localparam logic [1:0] CMD_WRITE = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_BURST = 2'd2;
    localparam logic [1:0] CMD_RSVD  = 2'd3;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_LAT,
        ST_TX
`ifdef MEM_CTRL_CSUM_EN
        , ST_CSUM
`endif
    } state_t;

endpackage

// File: rtl/mem_ctrl_ser.sv
// Word-to-byte serialiser, LSB first, valid/ready output; optional XOR checksum
// byte when MEM_CTRL_CSUM_EN is defined.
module mem_ctrl_ser
    import mem_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_start,
    input  logic        i_load,
    input  logic [31:0] i_word,
    input  logic        i_csum_load,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_word_done
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [31:0] shift_q;
    logic [1:0]  byte_cnt_q;
    logic        hs;

    // Handshake: a byte is consumed when valid and ready are both high at a clock edge.
    assign hs          = o_tx_valid & i_tx_ready;
    assign o_word_done = hs && (byte_cnt_q == LAST_BYTE);
    assign o_tx_data   = shift_q[7:0];

`ifdef MEM_CTRL_CSUM_EN
    logic [7:0] acc_q;
    logic       csum_phase_q;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            acc_q        <= 8'h00;
            csum_phase_q <= 1'b0;
        end else begin
            if (i_start)
                acc_q <= 8'h00;
            else if (hs && !csum_phase_q)
                acc_q <= acc_q ^ shift_q[7:0];
            if (i_load)
                csum_phase_q <= 1'b0;
            else if (i_csum_load)
                csum_phase_q <= 1'b1;
        end
    end
`else
    logic unused_csum;
    assign unused_csum = i_csum_load ^ i_start;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            shift_q    <= 32'h0;
            byte_cnt_q <= 2'd0;
            o_tx_valid <= 1'b0;
        end else if (i_load) begin
            shift_q    <= i_word;
            byte_cnt_q <= 2'd0;
            o_tx_valid <= 1'b1;
`ifdef MEM_CTRL_CSUM_EN
        end else if (i_csum_load) begin
            // Loaded on the last data handshake, so fold that byte in here.
            shift_q    <= {24'h0, acc_q ^ shift_q[7:0]};
            byte_cnt_q <= LAST_BYTE;
            o_tx_valid <= 1'b1;
`endif
        end else if (hs) begin
            shift_q    <= shift_q >> 8;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == LAST_BYTE)
                o_tx_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Command sequencer between the UART decoder and a single-port RAM; read data
// leaves as a byte stream. MEM_CTRL_CSUM_EN adds a trailing XOR checksum byte.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int BURST_W = 8
) (
    input  logic              i_clk,
    input  logic              i_nrst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_data,
    output logic              o_ram_en,
    output logic              o_ram_we,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    input  logic [31:0]       i_ram_rdata,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_ready,
    output logic              o_err,
    output logic              o_busy
);

    localparam logic [BURST_W:0] ONE_WORD = (BURST_W + 1)'(1);

    state_t           state_q;
    logic [BURST_W:0] words_q;
    logic             accept;
    logic             bad_cmd;
    logic             ser_load;
    logic             csum_load;
    logic             word_done;

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_busy      = ~o_cmd_ready;
    assign accept      = i_cmd_valid & o_cmd_ready;
    assign bad_cmd     = (i_addr[31:ADDR_W] != '0) || (i_cmd == CMD_RSVD);
    assign ser_load    = (state_q == ST_RD_LAT);
`ifdef MEM_CTRL_CSUM_EN
    assign csum_load   = (state_q == ST_TX) && word_done && (words_q == ONE_WORD);
`else
    assign csum_load   = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= ST_IDLE;
            words_q     <= '0;
            o_ram_en    <= 1'b0;
            o_ram_we    <= 1'b0;
            o_ram_addr  <= '0;
            o_ram_wdata <= 32'h0;
            o_err       <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (bad_cmd) begin
                            o_err <= 1'b1;
                        end else begin
                            o_ram_addr  <= i_addr[ADDR_W-1:0];
                            o_ram_wdata <= i_data;
                            o_ram_en    <= 1'b1;
                            if (i_cmd == CMD_WRITE) begin
                                o_ram_we <= 1'b1;
                                state_q  <= ST_WR;
                            end else begin
                                o_ram_we <= 1'b0;
                                words_q  <= (i_cmd == CMD_BURST) ?
                                            {1'b0, i_data[BURST_W-1:0]} + ONE_WORD : ONE_WORD;
                                state_q  <= ST_RD;
                            end
                        end
                    end
                end
                ST_WR: begin
                    o_ram_en <= 1'b0;
                    o_ram_we <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                ST_RD: begin
                    o_ram_en <= 1'b0;
                    state_q  <= ST_RD_LAT;
                end
                ST_RD_LAT: state_q <= ST_TX;
                ST_TX: begin
                    if (word_done) begin
                        words_q <= words_q - ONE_WORD;
                        if (words_q != ONE_WORD) begin
                            o_ram_addr <= o_ram_addr + 1'b1;
                            o_ram_en   <= 1'b1;
                            state_q    <= ST_RD;
                        end else begin
`ifdef MEM_CTRL_CSUM_EN
                            state_q <= ST_CSUM;
`else
                            state_q <= ST_IDLE;
`endif
                        end
                    end
                end
`ifdef MEM_CTRL_CSUM_EN
                ST_CSUM: if (word_done) state_q <= ST_IDLE;
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mem_ctrl_ser u_ser (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_start     (accept),
        .i_load      (ser_load),
        .i_word      (i_ram_rdata),
        .i_csum_load (csum_load),
        .o_tx_valid  (o_tx_valid),
        .o_tx_data   (o_tx_data),
        .i_tx_ready  (i_tx_ready),
        .o_word_done (word_done)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed steps plus randomized bursts
// compared against a word-array / byte-queue reference model.
`timescale 1ns/1ps
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int BURST_W = 8;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              i_clk = 1'b0;
    logic              i_nrst = 1'b0;
    logic              i_cmd_valid = 1'b0;
    logic              o_cmd_ready;
    logic [1:0]        i_cmd = 2'd0;
    logic [31:0]       i_addr = 32'h0;
    logic [31:0]       i_data = 32'h0;
    logic              o_ram_en;
    logic              o_ram_we;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [31:0]       o_ram_wdata;
    logic [31:0]       i_ram_rdata;
    logic              o_tx_valid;
    logic [7:0]        o_tx_data;
    logic              i_tx_ready = 1'b1;
    logic              o_err;
    logic              o_busy;

    mem_ctrl #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) dut (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd       (i_cmd),
        .i_addr      (i_addr),
        .i_data      (i_data),
        .o_ram_en    (o_ram_en),
        .o_ram_we    (o_ram_we),
        .o_ram_addr  (o_ram_addr),
        .o_ram_wdata (o_ram_wdata),
        .i_ram_rdata (i_ram_rdata),
        .o_tx_valid  (o_tx_valid),
        .o_tx_data   (o_tx_data),
        .i_tx_ready  (i_tx_ready),
        .o_err       (o_err),
        .o_busy      (o_busy)
    );

    // ---------------- clock / RAM model / watchdog ----------------
    always #5 i_clk = ~i_clk;

    logic [31:0] ram [DEPTH];
    always @(posedge i_clk) begin
        if (o_ram_en) begin
            if (o_ram_we) ram[o_ram_addr] <= o_ram_wdata;
            else          i_ram_rdata     <= ram[o_ram_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    logic [31:0]       ref_mem [DEPTH];
    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int                pass_cnt = 0;
    int                check_cnt = 0;
    int                fail_cnt = 0;
    bit                bp_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected RAM addresses and bytes for reading nwords from addr.
    task automatic expect_read(input int addr, input int nwords);
        logic [7:0]  x;
        logic [31:0] w;
        x = 8'h00;
        for (int i = 0; i < nwords; i++) begin
            int a;
            a = (addr + i) % DEPTH;
            exp_addr_q.push_back(ADDR_W'(a));
            w = ref_mem[a];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
`ifdef MEM_CTRL_CSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Byte/address monitor and hold-stability checker, sampled on the falling edge.
    initial begin
        logic       hold_v;
        logic [7:0] hold_d;
        hold_v = 1'b0;
        hold_d = 8'h00;
        forever begin
            @(negedge i_clk);
            if (!i_nrst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check("tx_hold_valid", {31'b0, o_tx_valid}, 32'd1);
                    check("tx_hold_data", {24'b0, o_tx_data}, {24'b0, hold_d});
                end
                if (o_ram_en && !o_ram_we) begin
                    if (exp_addr_q.size() == 0) check("rd_addr_unexpected", 32'(exp_addr_q.size()), 32'd1);
                    else check("rd_addr", {24'b0, o_ram_addr}, {24'b0, exp_addr_q.pop_front()});
                end
                if (o_tx_valid && i_tx_ready) begin
                    if (exp_q.size() == 0) check("tx_byte_unexpected", 32'(exp_q.size()), 32'd1);
                    else check("tx_byte", {24'b0, o_tx_data}, {24'b0, exp_q.pop_front()});
                end
                hold_v = o_tx_valid && !i_tx_ready;
                hold_d = o_tx_data;
            end
        end
    end

    // TX ready driver: always ready unless backpressure is enabled.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            i_tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_cmd_ready && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_cmd_ready) check("cmd_ready_wait", {31'b0, o_cmd_ready}, 32'd1);
        i_cmd       = cmd;
        i_addr      = addr;
        i_data      = data;
        i_cmd_valid = 1'b1;
        @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    task automatic do_write(input int addr, input logic [31:0] data);
        send_cmd(CMD_WRITE, 32'(addr), data);
        ref_mem[addr] = data;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!(o_cmd_ready && exp_q.size() == 0 && exp_addr_q.size() == 0) && n < budget);
        check("drain_idle", {31'b0, o_cmd_ready && exp_q.size() == 0 && exp_addr_q.size() == 0}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, o_cmd_ready}, 32'd1);
        check({tag, "_busy"},  {31'b0, o_busy}, 32'd0);
        check({tag, "_en"},    {31'b0, o_ram_en}, 32'd0);
        check({tag, "_we"},    {31'b0, o_ram_we}, 32'd0);
        check({tag, "_addr"},  {24'b0, o_ram_addr}, 32'd0);
        check({tag, "_wdata"}, o_ram_wdata, 32'd0);
        check({tag, "_txv"},   {31'b0, o_tx_valid}, 32'd0);
        check({tag, "_txd"},   {24'b0, o_tx_data}, 32'd0);
        check({tag, "_err"},   {31'b0, o_err}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int a;
        int len;
        int n;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

        // Reset state
        #12;
        check_reset_outputs("reset");
        @(negedge i_clk);
        i_nrst = 1'b1;

        // WRITE 0x05 <= 0xDEADBEEF: one write cycle, one busy cycle
        do_write(5, 32'hDEADBEEF);
        check("wr_en",    {31'b0, o_ram_en}, 32'd1);
        check("wr_we",    {31'b0, o_ram_we}, 32'd1);
        check("wr_addr",  {24'b0, o_ram_addr}, 32'h05);
        check("wr_wdata", o_ram_wdata, 32'hDEADBEEF);
        check("wr_busy",  {31'b0, o_busy}, 32'd1);
        @(posedge i_clk);
        #1;
        check("wr_en_off", {31'b0, o_ram_en}, 32'd0);
        check("wr_ready",  {31'b0, o_cmd_ready}, 32'd1);

        // READ 0x05: first valid on the third edge counting the accept edge
        expect_read(5, 1);
        send_cmd(CMD_READ, 32'h05, 32'h0);
        check("rd_en",   {31'b0, o_ram_en}, 32'd1);
        check("rd_we",   {31'b0, o_ram_we}, 32'd0);
        check("rd_lat1", {31'b0, o_tx_valid}, 32'd0);
        @(posedge i_clk);
        #1;
        check("rd_lat2", {31'b0, o_tx_valid}, 32'd0);
        @(posedge i_clk);
        #1;
        check("rd_lat3", {31'b0, o_tx_valid}, 32'd1);
        check("rd_first_byte", {24'b0, o_tx_data}, 32'hEF);
        wait_idle(200);

        // Fill the rest of the RAM with random words
        for (int i = 0; i < DEPTH; i++)
            if (i != 5) do_write(i, $urandom);

        // Burst wrap 0xFF -> 0x00; a command strobed while busy must be ignored
        expect_read(DEPTH - 1, 2);
        send_cmd(CMD_BURST, 32'(DEPTH - 1), 32'h1);
        i_cmd = CMD_WRITE; i_addr = 32'h30; i_data = 32'h0BADF00D; i_cmd_valid = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_cmd_valid = 1'b0;
        wait_idle(200);
        expect_read(32'h30, 1);
        send_cmd(CMD_READ, 32'h30, 32'h0);
        wait_idle(200);

        // Randomized bursts and reads under pseudo-random backpressure
        bp_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a   = $urandom_range(0, DEPTH - 1);
            len = $urandom_range(0, 7);
            if (k % 3 == 2) begin
                expect_read(a, 1);
                send_cmd(CMD_READ, 32'(a), $urandom);
            end else begin
                expect_read(a, len + 1);
                send_cmd(CMD_BURST, 32'(a), ($urandom & 32'hFFFF_FF00) | 32'(len));
            end
            wait_idle(3000);
        end
        bp_en = 1'b0;

        // Errors: out-of-range address and reserved command
        send_cmd(CMD_WRITE, 32'h100, 32'h12345678);
        check("err_addr_pulse", {31'b0, o_err}, 32'd1);
        check("err_addr_no_en", {31'b0, o_ram_en}, 32'd0);
        check("err_addr_ready", {31'b0, o_cmd_ready}, 32'd1);
        @(posedge i_clk);
        #1;
        check("err_addr_clear", {31'b0, o_err}, 32'd0);
        check("err_addr_no_en2", {31'b0, o_ram_en}, 32'd0);
        send_cmd(CMD_RSVD, 32'h10, 32'h0);
        check("err_rsvd_pulse", {31'b0, o_err}, 32'd1);
        check("err_rsvd_no_en", {31'b0, o_ram_en}, 32'd0);
        @(posedge i_clk);
        #1;
        check("err_rsvd_clear", {31'b0, o_err}, 32'd0);
        expect_read(0, 1);
        send_cmd(CMD_READ, 32'h0, 32'h0);
        wait_idle(200);

        // Reset in the middle of a burst
        expect_read(32'h40, 4);
        send_cmd(CMD_BURST, 32'h40, 32'h3);
        n = 0;
        while (!o_tx_valid && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("mid_valid_seen", {31'b0, o_tx_valid}, 32'd1);
        #1;
        i_nrst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge i_clk);
        check("midrst_hold_txv", {31'b0, o_tx_valid}, 32'd0);
        i_nrst = 1'b1;
        @(negedge i_clk);
        check("post_rst_ready", {31'b0, o_cmd_ready}, 32'd1);
        check("post_rst_en",    {31'b0, o_ram_en}, 32'd0);
        expect_read(7, 1);
        send_cmd(CMD_READ, 32'h7, 32'h0);
        wait_idle(200);

        repeat (3) @(negedge i_clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
